uart_host_rx: RTL and testbench

- Host-side serial receiver: the far end of the CPU's UART Tx line.
- Deserializes 8N1 frames sent by riscv_top, buffers bytes in a small FIFO and exposes them over a show-ahead read interface.
- Used as a simulation console in the testbench (bytes to $write) and as an on-board loopback checker.
- One clock domain; the serial input is asynchronous to it.

---
 rtl/uart_host_rx.sv | 154 +++++++++++++++
 tb/tb_uart_host_rx.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/uart_host_rx.sv
// Host-side 8N1 serial receiver with a small show-ahead FIFO.
// It deserializes frames from the CPU Tx line and queues the received bytes.
// frame_err and overrun are registered one-cycle pulses.
module uart_host_rx #(
  parameter int CLKS_PER_BIT    = 868,
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rx_in,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       empty,
  output logic       full,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int AW    = FIFO_DEPTH_LOG2;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  // Synchronizer taps: rx_p1 is the usable line, rx_p2 its previous sample
  logic          rx_p0, rx_p1, rx_p2;
  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_q;
  logic          samp, cnt_clr, push, ferr_n;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_n;
  logic          pop, wr, ovr_n;

  // Stage p0..p2: two-flop synchronizer plus one history tap, idle-high on reset
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
      rx_p2 <= 1'b1;
    end else begin
      rx_p0 <= rx_in;
      rx_p1 <= rx_p0;
      rx_p2 <= rx_p1;
    end
  end

  // FSM state register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next-state logic; IDLE needs a true falling edge, so a line held low never starts a frame
  always_comb begin
    state_n = state;
    samp    = 1'b0;
    cnt_clr = 1'b0;
    push    = 1'b0;
    ferr_n  = 1'b0;
    case (state)
      S_IDLE:  if (rx_p2 && !rx_p1) state_n = S_START;
      S_START: if (cnt == CNT_HALF) state_n = rx_p1 ? S_IDLE : S_DATA;
      S_DATA: begin
        if (cnt == CNT_LAST) begin
          samp    = 1'b1;
          cnt_clr = 1'b1;
          if (bit_idx == 3'd7) state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt == CNT_LAST) begin
          if (rx_p1) begin
            push    = 1'b1;
            state_n = S_IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = S_BREAK;
          end
        end
      end
      S_BREAK: if (rx_p1) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Baud counter restarts on every state entry and after each data-bit sample
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)                             cnt <= '0;
    else if ((state_n != state) || cnt_clr) cnt <= '0;
    else                                    cnt <= cnt + CW'(1);
  end

  // Bit index: cleared while in START, advanced on each data sample
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)               bit_idx <= '0;
    else if (state == S_START) bit_idx <= '0;
    else if (samp)            bit_idx <= bit_idx + 3'd1;
  end

  // LSB-first shift register; after eight samples bit 0 sits in shift_q[0]
  always_ff @(posedge clk_in) begin
    if (samp) shift_q <= {rx_p1, shift_q[7:1]};
  end

  assign pop   = rd_en && !empty;
  assign wr    = push && (!full || pop);
  assign ovr_n = push && full && !pop;

  // Occupancy update for every push/pop combination
  always_comb begin
    count_n = count;
    case ({wr, pop})
      2'b10:   count_n = count + (AW + 1)'(1);
      2'b01:   count_n = count - (AW + 1)'(1);
      default: count_n = count;
    endcase
  end

  // FIFO storage; written at the tail on an accepted push
  always_ff @(posedge clk_in) begin
    if (wr) mem[wr_ptr] <= shift_q;
  end

  // FIFO control plus registered flags and status pulses
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count     <= count_n;
      empty     <= (count_n == '0);
      full      <= (count_n == CNT_FULL);
      frame_err <= ferr_n;
      overrun   <= ovr_n;
    end
  end

  assign rd_data = empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: tb/tb_uart_host_rx.sv
// Directed testbench for uart_host_rx with CLKS_PER_BIT=4 and an 8-entry FIFO.
module tb_uart_host_rx;

  localparam int C = 4;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       rx_in;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty, full, frame_err, overrun;

  int vecs = 0;
  int errs = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  int both_cnt = 0;
  int ferr_base, ovr_base;

  uart_host_rx #(.CLKS_PER_BIT(C), .FIFO_DEPTH_LOG2(3)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rx_in(rx_in), .rd_en(rd_en),
    .rd_data(rd_data), .empty(empty), .full(full),
    .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk_in = ~clk_in;

  // Pulse monitor for the one-cycle status outputs
  always @(posedge clk_in) begin
    if (frame_err) ferr_cnt++;
    if (overrun) ovr_cnt++;
    if (frame_err && overrun) both_cnt++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  // Drives a whole frame; returns inside the cycle in which the stop bit is sampled
  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    rx_in = 1'b0;
    tick(C);
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      tick(C);
    end
    rx_in = stop_bit;
    tick(C);
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    check(tag, 32'(rd_data), 32'(exp));
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  initial begin
    rst_in = 1'b1;
    rx_in  = 1'b1;
    rd_en  = 1'b0;
    tick(3);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'h00);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    rst_in = 1'b0;
    tick(3);

    // Single byte
    ferr_base = ferr_cnt;
    ovr_base  = ovr_cnt;
    send_frame(8'h55, 1'b1);
    check("single_empty_at_sample", 32'(empty), 32'd1);
    tick(1);
    check("single_empty_after", 32'(empty), 32'd0);
    check("single_rd_data", 32'(rd_data), 32'h55);
    tick(2);
    check("single_no_ferr", 32'(ferr_cnt - ferr_base), 32'd0);
    check("single_no_ovr", 32'(ovr_cnt - ovr_base), 32'd0);
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    check("single_empty_popped", 32'(empty), 32'd1);
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    check("pop_while_empty", 32'(empty), 32'd1);

    // Back-to-back fill with one overrun
    ovr_base = ovr_cnt;
    for (int i = 1; i <= 9; i++) begin
      send_frame(8'(i), 1'b1);
      if (i == 8) check("fill_not_full_before_8", 32'(full), 32'd0);
    end
    tick(3);
    check("fill_full", 32'(full), 32'd1);
    check("fill_overrun_once", 32'(ovr_cnt - ovr_base), 32'd1);
    for (int i = 1; i <= 8; i++) pop_check("fill_drain", 8'(i));
    check("fill_empty_end", 32'(empty), 32'd1);
    check("fill_not_full_end", 32'(full), 32'd0);

    // Simultaneous push and pop at full
    for (int i = 0; i < 8; i++) send_frame(8'h11 + 8'(i), 1'b1);
    ovr_base = ovr_cnt;
    send_frame(8'hA5, 1'b1);
    check("pp_full_before", 32'(full), 32'd1);
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    tick(2);
    check("pp_full_kept", 32'(full), 32'd1);
    check("pp_no_overrun", 32'(ovr_cnt - ovr_base), 32'd0);
    for (int i = 1; i < 8; i++) pop_check("pp_drain", 8'h11 + 8'(i));
    pop_check("pp_last_a5", 8'hA5);
    check("pp_empty_end", 32'(empty), 32'd1);

    // Framing error followed by a held-low break
    ferr_base = ferr_cnt;
    send_frame(8'h3C, 1'b0);
    tick(40);
    rx_in = 1'b1;
    tick(10);
    check("ferr_once", 32'(ferr_cnt - ferr_base), 32'd1);
    check("ferr_empty", 32'(empty), 32'd1);
    send_frame(8'h7E, 1'b1);
    tick(1);
    check("after_break_empty", 32'(empty), 32'd0);
    pop_check("after_break_7e", 8'h7E);

    // Start glitch
    ferr_base = ferr_cnt;
    rx_in = 1'b0;
    tick(1);
    rx_in = 1'b1;
    tick(20);
    check("glitch_empty", 32'(empty), 32'd1);
    check("glitch_no_ferr", 32'(ferr_cnt - ferr_base), 32'd0);
    send_frame(8'h0F, 1'b1);
    tick(1);
    pop_check("glitch_then_0f", 8'h0F);

    // Reset mid-frame with two bytes queued
    send_frame(8'h21, 1'b1);
    send_frame(8'h22, 1'b1);
    tick(1);
    check("mid_queued", 32'(empty), 32'd0);
    rx_in = 1'b0;
    tick(C);
    for (int i = 0; i < 4; i++) begin
      rx_in = 1'b0;
      tick(C);
    end
    rx_in = 1'b1;
    tick(2);
    #2 rst_in = 1'b1;
    #1;
    check("mid_rst_empty", 32'(empty), 32'd1);
    check("mid_rst_full", 32'(full), 32'd0);
    check("mid_rst_rd_data", 32'(rd_data), 32'h00);
    tick(3);
    rst_in = 1'b0;
    tick(40);
    check("mid_partial_dropped", 32'(empty), 32'd1);
    send_frame(8'hC3, 1'b1);
    tick(1);
    pop_check("mid_next_c3", 8'hC3);
    check("mid_empty_end", 32'(empty), 32'd1);

    tick(2);
    check("total_ferr", 32'(ferr_cnt), 32'd1);
    check("total_ovr", 32'(ovr_cnt), 32'd1);
    check("never_both", 32'(both_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
